// File: rtl/ram_ctrl.sv
// Request sequencer for the 8x8 SRAM: single-byte read/write over valid/ready,
// and a clear sweep that writes CLR_VALUE to all eight addresses.
module ram_ctrl #(
    parameter logic       WR_OP     = 1'b1,
    parameter int         RD_WAIT   = 1,
    parameter logic [7:0] CLR_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       clr_start,
    output logic       busy,
    output logic       clr_done,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [7:0] ram_inp,
    output logic [2:0] ram_addr,
    output logic       ram_op,
    output logic       ram_sel,
    input  logic [7:0] ram_outp
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_* are ignored in every other cycle.

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_REL,
        RD,
        RD_CAP,
        CLR_WR,
        CLR_REL
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(RD_WAIT - 1);

    state_t     state_q, state_d;
    logic       sel_q, sel_d;
    logic       op_q, op_d;
    logic [7:0] inp_q, inp_d;
    logic [2:0] addr_q, addr_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rdata_q, rdata_d;
    logic       clr_done_q, clr_done_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] wait_q, wait_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            op_q        <= ~WR_OP;
            inp_q       <= 8'h00;
            addr_q      <= 3'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
            clr_done_q  <= 1'b0;
            cnt_q       <= 3'd0;
            wait_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            op_q        <= op_d;
            inp_q       <= inp_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            clr_done_q  <= clr_done_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        op_d        = op_q;
        inp_d       = inp_q;
        addr_d      = addr_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        clr_done_d  = 1'b0;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        case (state_q)
            IDLE: begin
                // A clear request takes priority and blocks the same-cycle request.
                if (clr_start) begin
                    state_d = CLR_WR;
                    sel_d   = 1'b1;
                    op_d    = WR_OP;
                    inp_d   = CLR_VALUE;
                    addr_d  = 3'd0;
                    cnt_d   = 3'd0;
                end else if (req_valid) begin
                    sel_d  = 1'b1;
                    addr_d = req_addr;
                    wait_d = 2'd0;
                    if (req_we) begin
                        state_d = WR;
                        op_d    = WR_OP;
                        inp_d   = req_wdata;
                    end else begin
                        state_d = RD;
                        op_d    = ~WR_OP;
                    end
                end
            end
            WR: begin
                sel_d   = 1'b0;
                state_d = WR_REL;
            end
            WR_REL: state_d = IDLE;
            RD: begin
                if (wait_q == WAIT_LAST) begin
                    sel_d       = 1'b0;
                    rdata_d     = ram_outp;
                    rsp_valid_d = 1'b1;
                    state_d     = RD_CAP;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            RD_CAP: state_d = IDLE;
            CLR_WR: begin
                sel_d   = 1'b0;
                state_d = CLR_REL;
            end
            CLR_REL: begin
                if (cnt_q == 3'd7) begin
                    clr_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    addr_d  = cnt_q + 3'd1;
                    sel_d   = 1'b1;
                    state_d = CLR_WR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE) && !clr_start;
    assign busy      = (state_q != IDLE);
    assign clr_done  = clr_done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign ram_inp   = inp_q;
    assign ram_addr  = addr_q;
    assign ram_op    = op_q;
    assign ram_sel   = sel_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl driving a behavioural 8x8 SRAM model.
module tb_ram_ctrl;

    localparam int         RD_WAIT   = 2;
    localparam logic [7:0] CLR_VALUE = 8'h00;

    logic       clk, rst;
    logic       req_valid, req_ready, req_we;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       clr_start, busy, clr_done, rsp_valid;
    logic [7:0] rsp_rdata, ram_inp, ram_outp;
    logic [2:0] ram_addr;
    logic       ram_op, ram_sel;

    int vectors = 0;
    int errors  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem[8];

    ram_ctrl #(.WR_OP(1'b1), .RD_WAIT(RD_WAIT), .CLR_VALUE(CLR_VALUE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_inp(ram_inp), .ram_addr(ram_addr), .ram_op(ram_op),
        .ram_sel(ram_sel), .ram_outp(ram_outp)
    );

    // Clock / reset and SRAM model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (ram_sel && ram_op == 1'b1) mem[ram_addr] <= ram_inp;
    end

    assign ram_outp = mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Address and data must hold steady across consecutive select cycles.
    logic       sel_prev  = 1'b0;
    logic [2:0] addr_prev = 3'd0;
    logic [7:0] inp_prev  = 8'h00;
    always @(negedge clk) begin
        if (!rst && ram_sel && sel_prev) begin
            check("sel_addr_stable", 32'(ram_addr), 32'(addr_prev));
            check("sel_inp_stable", 32'(ram_inp), 32'(inp_prev));
        end
        sel_prev  = ram_sel;
        addr_prev = ram_addr;
        inp_prev  = ram_inp;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
        check("wr_sel_high", 32'(ram_sel), 32'd1);
        check("wr_op", 32'(ram_op), 32'd1);
        check("wr_addr", 32'(ram_addr), 32'(a));
        check("wr_inp", 32'(ram_inp), 32'(d));
        check("wr_ready_low", 32'(req_ready), 32'd0);
        tick();
        check("wrrel_sel_low", 32'(ram_sel), 32'd0);
        check("wrrel_ready_low", 32'(req_ready), 32'd0);
        check("wrrel_inp_hold", 32'(ram_inp), 32'(d));
        tick();
        check("wr_back_idle", 32'(req_ready), 32'd1);
    endtask

    task automatic do_read(input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] e;
        wait_ready();
        exp_q.push_back(exp);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'h5A;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < RD_WAIT; i++) begin
            check("rd_sel_high", 32'(ram_sel), 32'd1);
            check("rd_op", 32'(ram_op), 32'd0);
            check("rd_ready_low", 32'(req_ready), 32'd0);
            check("rd_no_early_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        e = exp_q.pop_front();
        check("rdcap_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rdcap_rdata", 32'(rsp_rdata), 32'(e));
        check("rdcap_sel_low", 32'(ram_sel), 32'd0);
        check("rdcap_ready_low", 32'(req_ready), 32'd0);
        tick();
        check("rsp_pulse_one", 32'(rsp_valid), 32'd0);
        check("rdata_held", 32'(rsp_rdata), 32'(e));
    endtask

    // Caller raises clr_start just before calling; returns with ctrl idle.
    task automatic clear_sweep(input string tag);
        int   bcnt = 0;
        logic early_done = 1'b0;
        logic rsp_seen = 1'b0;
        tick();
        clr_start = 1'b0;
        req_valid = 1'b0;
        while (busy && bcnt < 40) begin
            if (clr_done) early_done = 1'b1;
            if (rsp_valid) rsp_seen = 1'b1;
            bcnt++;
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd16);
        check({tag, "_no_early_done"}, 32'(early_done), 32'd0);
        check({tag, "_no_rsp"}, 32'(rsp_seen), 32'd0);
        check({tag, "_done"}, 32'(clr_done), 32'd1);
        tick();
        check({tag, "_done_pulse"}, 32'(clr_done), 32'd0);
    endtask

    initial begin
        int last, accepts, rsp_cnt;
        logic done_seen;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 3'd0;
        req_wdata = 8'h00; clr_start = 1'b0;

        // 1: reset values
        tick(); tick();
        rst = 1'b0;
        check("rst_sel", 32'(ram_sel), 32'd0);
        check("rst_op", 32'(ram_op), 32'd0);
        check("rst_inp", 32'(ram_inp), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_clr_done", 32'(clr_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);

        // 2: single write / read
        do_write(3'd3, 8'hA5);
        do_read(3'd3, 8'hA5);

        // 3: fill ascending, read back descending
        for (int i = 0; i < 8; i++) do_write(3'(i), 8'h10 + 8'(i));
        for (int i = 7; i >= 0; i--) do_read(3'(i), 8'h10 + 8'(i));

        // 4: clear wins over a simultaneous request
        for (int i = 0; i < 8; i++) do_write(3'(i), 8'hFF);
        clr_start = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2;
        #1;
        check("clr_blocks_ready", 32'(req_ready), 32'd0);
        clear_sweep("clr");
        for (int i = 0; i < 8; i++) do_read(3'(i), 8'h00);

        // 5: reset in cycle 5 of a sweep
        for (int i = 0; i < 8; i++) do_write(3'(i), 8'hC3);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sel", 32'(ram_sel), 32'd0);
        check("mid_rst_addr", 32'(ram_addr), 32'd0);
        check("mid_rst_clr_done", 32'(clr_done), 32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (clr_done) done_seen = 1'b1;
            tick();
        end
        check("mid_rst_no_done_later", 32'(done_seen), 32'd0);
        do_read(3'd7, 8'hC3);
        clr_start = 1'b1;
        clear_sweep("reclr");
        do_read(3'd7, 8'h00);

        // 6: back-to-back reads with valid held high
        do_write(3'd5, 8'h6E);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd5;
        last = -1; accepts = 0; rsp_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (req_ready) begin
                if (last >= 0) check("b2b_interval", 32'(c - last), 32'(RD_WAIT + 2));
                last = c;
                accepts++;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                check("b2b_rdata", 32'(rsp_rdata), 32'h6E);
            end
            tick();
        end
        req_valid = 1'b0;
        check("b2b_accepts", 32'(accepts), 32'd10);
        check("b2b_rsp_count", 32'(rsp_cnt), 32'd10);
        tick(); tick(); tick(); tick();
        check("b2b_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
